// File: rtl/sr_design_sync.sv
// sr_design_sync: clocked replacement for a NAND-style SR latch with active-low
// set/reset inputs. Optional synchronizer flops on s and r feed a small state
// register that drives q, qbar and a flag for the forbidden (both active) input.
// Every path is registered, so the outputs cannot glitch, oscillate or go X.
module sr_design_sync #(
  parameter int   SYNC_STAGES = 2,    // 0..3; 0 means s/r are already synchronous
  parameter logic RESET_Q     = 1'b0  // q value after reset, qbar takes the inverse
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qbar,
  output logic invalid
);

  logic ss;  // s after the synchronizer
  logic rs;  // r after the synchronizer

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign ss = s;
      assign rs = r;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] s_sync_reg;
      logic [SYNC_STAGES-1:0] r_sync_reg;

      // Shift chain; flops idle at 1 so reset looks like "no request".
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_sync_reg <= '1;
          r_sync_reg <= '1;
        end else begin
          s_sync_reg[0] <= s;
          r_sync_reg[0] <= r;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            s_sync_reg[i] <= s_sync_reg[i-1];
            r_sync_reg[i] <= r_sync_reg[i-1];
          end
        end
      end

      assign ss = s_sync_reg[SYNC_STAGES-1];
      assign rs = r_sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic q_reg, q_next;
  logic qbar_reg, qbar_next;
  logic invalid_reg, invalid_next;

  // Latch state register with asynchronous reset to the configured value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= RESET_Q;
      qbar_reg    <= ~RESET_Q;
      invalid_reg <= 1'b0;
    end else begin
      q_reg       <= q_next;
      qbar_reg    <= qbar_next;
      invalid_reg <= invalid_next;
    end
  end

  // Next-state decode from the synchronized set/reset pair.
  always_comb begin
    q_next       = q_reg;
    qbar_next    = qbar_reg;
    invalid_next = invalid_reg;
    unique case ({ss, rs})
      2'b01: begin  // set request
        q_next       = 1'b1;
        qbar_next    = 1'b0;
        invalid_next = 1'b0;
      end
      2'b10: begin  // reset request
        q_next       = 1'b0;
        qbar_next    = 1'b1;
        invalid_next = 1'b0;
      end
      2'b00: begin  // both active: NAND-faithful outputs, flagged
        q_next       = 1'b1;
        qbar_next    = 1'b1;
        invalid_next = 1'b1;
      end
      default: begin  // 2'b11: hold, but a release from forbidden settles reset-dominant
        if (invalid_reg) begin
          q_next       = 1'b0;
          qbar_next    = 1'b1;
          invalid_next = 1'b0;
        end
      end
    endcase
  end

  assign q       = q_reg;
  assign qbar    = qbar_reg;
  assign invalid = invalid_reg;

endmodule

// File: tb/tb_sr_design_sync.sv
// Testbench for sr_design_sync: four instances with different synchronizer depth
// and reset value share one stimulus; a behavioural model tracks each of them.
module tb_sr_design_sync;

  logic clk;
  logic rst_n;
  logic s;
  logic r;

  logic q0, qb0, iv0;
  logic q1, qb1, iv1;
  logic q2, qb2, iv2;
  logic q3, qb3, iv3;

  // Configurations: A(0,0) B(2,0) C(0,1) D(3,1) as (SYNC_STAGES, RESET_Q)
  localparam int NS [4] = '{0, 2, 0, 3};
  localparam bit RQ [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  sr_design_sync #(.SYNC_STAGES(0), .RESET_Q(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .q(q0), .qbar(qb0), .invalid(iv0));
  sr_design_sync #(.SYNC_STAGES(2), .RESET_Q(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .q(q1), .qbar(qb1), .invalid(iv1));
  sr_design_sync #(.SYNC_STAGES(0), .RESET_Q(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .q(q2), .qbar(qb2), .invalid(iv2));
  sr_design_sync #(.SYNC_STAGES(3), .RESET_Q(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .q(q3), .qbar(qb3), .invalid(iv3));

  logic [2:0] obs [4];
  assign obs[0] = {q0, qb0, iv0};
  assign obs[1] = {q1, qb1, iv1};
  assign obs[2] = {q2, qb2, iv2};
  assign obs[3] = {q3, qb3, iv3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: {q, qbar, invalid} per instance, plus a history of the
  // (s, r) pairs seen at past clock edges (front = most recent edge).
  logic [2:0] mdl [4];
  bit [1:0]   hist [$];

  function automatic logic [2:0] rule(bit [1:0] sr, logic [2:0] cur);
    case (sr)
      2'b00:   return 3'b111;
      2'b01:   return 3'b100;
      2'b10:   return 3'b010;
      default: return cur[0] ? 3'b010 : cur;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mdl[k] = {RQ[k], ~RQ[k], 1'b0};
    hist = '{2'b11, 2'b11, 2'b11, 2'b11};
  endtask

  task automatic model_edge();
    bit [1:0] seen;
    if (!rst_n) return;
    for (int k = 0; k < 4; k++) begin
      seen   = (NS[k] == 0) ? {s, r} : hist[NS[k]-1];
      mdl[k] = rule(seen, mdl[k]);
    end
    hist.push_front({s, r});
    void'(hist.pop_back());
  endtask

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] want);
    tests_run++;
    assert (got === want) else begin
      tests_failed++;
      $error("FAIL %s observed={q,qbar,inv}=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) chk($sformatf("%s/dut%0d", tag, k), obs[k], mdl[k]);
  endtask

  // One rising edge: update the model with the inputs present at the edge,
  // then sample outputs 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit [1:0] sr);
    s = sr[1];
    r = sr[0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  bit [1:0] basic_in  [4] = '{2'b01, 2'b11, 2'b10, 2'b11};
  bit [2:0] basic_exp [4] = '{3'b100, 3'b100, 3'b010, 3'b010};

  initial begin
    rst_n = 1'b1;
    s = 1'b0;
    r = 1'b1;
    hist = '{2'b11, 2'b11, 2'b11, 2'b11};

    // 1. Reset with set held: outputs forced before any edge
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    chk("reset_a_const", obs[0], 3'b010);
    chk("reset_c_const", obs[2], 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    step("release");
    chk("release_a_set", obs[0], 3'b100);

    // 2. Basic sequence, each pair held two edges
    for (int i = 0; i < 4; i++) begin
      drive(basic_in[i]);
      for (int e = 0; e < 2; e++) begin
        step("basic");
        chk($sformatf("basic_a_%0d_%0d", i, e), obs[0], basic_exp[i]);
      end
    end

    // 3. Forbidden then release: reset-dominant, stable afterwards
    drive(2'b00);
    step("forbid");
    chk("forbid_a", obs[0], 3'b111);
    drive(2'b11);
    step("forbid_rel");
    chk("forbid_rel_a", obs[0], 3'b010);
    for (int e = 0; e < 10; e++) begin
      step("forbid_hold");
      chk("forbid_hold_a", obs[0], 3'b010);
    end

    // 4. Forbidden exit to set
    drive(2'b00);
    step("forbid2");
    drive(2'b01);
    step("forbid_set");
    chk("forbid_set_a", obs[0], 3'b100);

    // 5. Latency through two synchronizer stages (instance B)
    drive(2'b10);
    for (int e = 0; e < 4; e++) step("lat_clr");
    drive(2'b01);
    step("lat1"); chk("lat_b_e1", {2'b00, q1}, 3'b000);
    step("lat2"); chk("lat_b_e2", {2'b00, q1}, 3'b000);
    step("lat3"); chk("lat_b_e3", {2'b00, q1}, 3'b001);
    drive(2'b10);
    for (int e = 0; e < 4; e++) step("pulse_clr");
    drive(2'b01);
    step("pulse1");
    drive(2'b11);
    step("pulse2"); chk("pulse_b_e2", {2'b00, q1}, 3'b000);
    step("pulse3"); chk("pulse_b_e3", {2'b00, q1}, 3'b001);
    step("pulse4"); chk("pulse_b_hold", {2'b00, q1}, 3'b001);

    // 6. Reset during forbidden, RESET_Q=1 instances
    drive(2'b00);
    for (int e = 0; e < 4; e++) step("mid_forbid");
    chk("mid_forbid_d", obs[3], 3'b111);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    chk("mid_reset_c", obs[2], 3'b100);
    chk("mid_reset_d", obs[3], 3'b100);
    step("mid_reset_edge");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model, with occasional async resets
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom_range(0, 3)));
      step($sformatf("rand%0d", i));
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rand_reset");
        step("rand_reset_edge");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
